// File: rtl/scan_convert_pkg.sv
// Shared sizing and pixel-word types for the scan converter and its line buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package scan_convert_pkg;

    localparam int BUF_DEPTH = 512;   // pixels held per line bank
    localparam int CNT_W     = 10;    // horizontal counter width
    localparam int PIX_W     = 9;     // stored word: blank + rgb

    typedef logic [CNT_W-1:0] cnt_t;

    // Stored pixel word; rgb packed as {B[1:0], G[2:0], R[2:0]}.
    typedef struct packed {
        logic       blank;
        logic [7:0] rgb;
    } pix_t;

endpackage

// File: rtl/line_buf_dp.sv
// Simple dual-port line RAM: one write port, one registered read port; bank select is the address MSB.
// Latency: read data appears 1 cycle after the read address.
// Backpressure: none; a same-address read and write in one cycle returns the data being written.
module line_buf_dp #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 9
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdat_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdat_o
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdat_q;

    // Write port plus write-first registered read.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdat_i;
        end
        if (we_i && (waddr_i == raddr_i)) begin
            rdat_q <= wdat_i;
        end else begin
            rdat_q <= mem_q[raddr_i];
        end
    end

    assign rdat_o = rdat_q;

endmodule

// File: rtl/scan_convert_lx45.sv
// Scan doubler: captures 15 kHz lines into a ping-pong line buffer and replays each line twice at clk12m rate.
// Latency: rgb/blank/hsync_o trail the output column counter by 2 cycles; vsync_o trails vsync_i by 2 cycles.
// Backpressure: none; free-running video, input side advances only on clk6m strobe cycles.
module scan_convert_lx45 #(
    parameter int BUF_DEPTH   = scan_convert_pkg::BUF_DEPTH,
    parameter int HSYNC_W     = 32,
    parameter int DEFAULT_LEN = 384
) (
    input  logic       clk12m,
    input  logic       reset,
    input  logic       clk6m,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic       blank_i,
    input  logic [7:0] rgb_i,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       blank_o,
    output logic [7:0] rgb_o
);
    import scan_convert_pkg::*;

    localparam int             LW      = $clog2(BUF_DEPTH);
    localparam int             AW      = LW + 1;
    localparam logic [CNT_W:0] BUF_LIM = (CNT_W+1)'(BUF_DEPTH);
    localparam cnt_t           HS_LIM  = cnt_t'(HSYNC_W);
    localparam cnt_t           DEF_LEN = cnt_t'(DEFAULT_LEN);
    localparam cnt_t           CNT_MAX = '1;
    localparam pix_t           PIX_OOB = '{blank: 1'b1, rgb: 8'h00};

    // Input-side state
    logic hs_prev_q;
    cnt_t hcount_i_q, hcount_i_d;
    cnt_t line_len_q, line_len_d;
    logic wsel_q, wsel_d;

    // Output-side state
    cnt_t hcount_o_q, hcount_o_d;
    logic pipe_vld_q, oob_q, hs_pipe_q, vs_pipe_q;
    logic hsync_o_q, vsync_o_q, blank_o_q;
    logic [7:0] rgb_o_q;

    logic          hs_rise;
    logic          rd_last;
    cnt_t          wr_col;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    pix_t          wr_dat;
    pix_t          rd_dat;
    pix_t          pix_word;

    // Rising hsync_i only counts on a pixel strobe, against the value seen on the previous strobe.
    assign hs_rise = clk6m & hsync_i & ~hs_prev_q;

    // The first pixel of a new line lands at column 0 of the bank being switched to.
    assign wr_col  = hs_rise ? '0 : hcount_i_q;
    assign wr_en   = clk6m & ~reset & ({1'b0, wr_col} < BUF_LIM);
    assign wr_addr = {wsel_d, wr_col[LW-1:0]};
    assign wr_dat  = {blank_i, rgb_i};
    assign rd_addr = {~wsel_q, hcount_o_q[LW-1:0]};
    assign rd_last = ({1'b0, hcount_o_q} + (CNT_W+1)'(1)) >= {1'b0, line_len_q};

    // Next-state for capture counter, bank select, measured line length and replay column.
    always_comb begin
        hcount_i_d = hcount_i_q;
        line_len_d = line_len_q;
        wsel_d     = wsel_q;
        hcount_o_d = rd_last ? '0 : hcount_o_q + cnt_t'(1);
        if (hs_rise) begin
            hcount_i_d = cnt_t'(1);
            wsel_d     = ~wsel_q;
            hcount_o_d = '0;
            if (hcount_i_q != '0) begin
                line_len_d = hcount_i_q;
            end
        end else if (clk6m && (hcount_i_q != CNT_MAX)) begin
            hcount_i_d = hcount_i_q + cnt_t'(1);
        end
    end

    // Counter and bank registers; reset abandons the current line but leaves the buffer alone.
    always_ff @(posedge clk12m) begin
        if (reset) begin
            hs_prev_q  <= 1'b0;
            hcount_i_q <= '0;
            line_len_q <= DEF_LEN;
            wsel_q     <= 1'b0;
            hcount_o_q <= '0;
        end else begin
            if (clk6m) begin
                hs_prev_q <= hsync_i;
            end
            hcount_i_q <= hcount_i_d;
            line_len_q <= line_len_d;
            wsel_q     <= wsel_d;
            hcount_o_q <= hcount_o_d;
        end
    end

    line_buf_dp #(
        .DEPTH (2 * BUF_DEPTH),
        .AW    (AW),
        .DW    (PIX_W)
    ) u_line_buf (
        .clk_i   (clk12m),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdat_i  (wr_dat),
        .raddr_i (rd_addr),
        .rdat_o  (rd_dat)
    );

    // Columns past the buffer read as blank; nothing is shown until the read pipe has refilled after reset.
    always_comb begin
        pix_word = '0;
        if (pipe_vld_q) begin
            pix_word = oob_q ? PIX_OOB : rd_dat;
        end
    end

    // Output pipeline: stage 1 runs alongside the RAM read, stage 2 drives the pins.
    always_ff @(posedge clk12m) begin
        if (reset) begin
            pipe_vld_q <= 1'b0;
            oob_q      <= 1'b0;
            hs_pipe_q  <= 1'b0;
            vs_pipe_q  <= 1'b0;
            hsync_o_q  <= 1'b0;
            vsync_o_q  <= 1'b0;
            blank_o_q  <= 1'b0;
            rgb_o_q    <= 8'h00;
        end else begin
            pipe_vld_q <= 1'b1;
            oob_q      <= ({1'b0, hcount_o_q} >= BUF_LIM);
            hs_pipe_q  <= (hcount_o_q < HS_LIM);
            vs_pipe_q  <= vsync_i;
            hsync_o_q  <= hs_pipe_q;
            vsync_o_q  <= vs_pipe_q;
            blank_o_q  <= pix_word.blank;
            rgb_o_q    <= pix_word.blank ? 8'h00 : pix_word.rgb;
        end
    end

    assign hsync_o = hsync_o_q;
    assign vsync_o = vsync_o_q;
    assign blank_o = blank_o_q;
    assign rgb_o   = rgb_o_q;

endmodule

// File: tb/tb_scan_convert_lx45.sv
// Randomised bench for the scan doubler: a line-buffer reference model feeds a scoreboard queue.
// Latency: the model accounts for the 2-cycle output pipeline itself.
// Backpressure: n/a; one expected entry is queued per clock and drained by the monitor.
module tb_scan_convert_lx45;

    localparam int BUF    = 512;
    localparam int HSW    = 32;
    localparam int DEFLEN = 384;

    logic       clk12m = 1'b0;
    logic       reset, clk6m, hsync_i, vsync_i, blank_i;
    logic [7:0] rgb_i;
    logic       hsync_o, vsync_o, blank_o;
    logic [7:0] rgb_o;

    always #5 clk12m = ~clk12m;

    scan_convert_lx45 #(
        .BUF_DEPTH   (BUF),
        .HSYNC_W     (HSW),
        .DEFAULT_LEN (DEFLEN)
    ) dut (
        .clk12m  (clk12m),
        .reset   (reset),
        .clk6m   (clk6m),
        .hsync_i (hsync_i),
        .vsync_i (vsync_i),
        .blank_i (blank_i),
        .rgb_i   (rgb_i),
        .hsync_o (hsync_o),
        .vsync_o (vsync_o),
        .blank_o (blank_o),
        .rgb_o   (rgb_o)
    );

    typedef struct {
        bit       hs;
        bit       vs;
        bit       known;   // pixel content is defined (buffer location written since time 0)
        bit       bl;
        bit [7:0] rgb;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_period = 0;  // expected hsync_o spacing in cycles, 0 = not checked

    // Reference model: two line stores, a capture position, a replay column.
    int   m_mem[2][1024];  // -1 marks never-written
    int   m_hcnt, m_len, m_col;
    bit   m_bank, m_prev_hs, m_v1;
    exp_t m_stage;

    task automatic model_edge(input bit rst, input bit ipc, input bit hs, input bit vs,
                              input bit bl, input bit [7:0] rgb);
        exp_t o;
        bit   rise, nb;
        int   a, w;
        if (rst) begin
            o.hs = 0; o.vs = 0; o.known = 1; o.bl = 0; o.rgb = 8'h00;
            m_stage = o;
            m_v1 = 0; m_hcnt = 0; m_col = 0; m_bank = 0; m_prev_hs = 0; m_len = DEFLEN;
        end else begin
            o    = m_stage;
            o.vs = m_v1;
            rise = ipc && hs && !m_prev_hs;
            nb   = rise ? !m_bank : m_bank;
            if (ipc) begin
                a = rise ? 0 : m_hcnt;
                if (a < BUF) m_mem[nb][a] = (bl ? 256 : 0) + int'(rgb);
            end
            m_stage.hs = (m_col < HSW);
            if (m_col >= BUF) begin
                m_stage.known = 1; m_stage.bl = 1; m_stage.rgb = 8'h00;
            end else begin
                w = m_mem[!m_bank][m_col];
                if (w < 0) begin
                    m_stage.known = 0; m_stage.bl = 0; m_stage.rgb = 8'h00;
                end else begin
                    m_stage.known = 1;
                    m_stage.bl    = (w >= 256);
                    m_stage.rgb   = (w >= 256) ? 8'h00 : 8'(w % 256);
                end
            end
            if (rise || (m_col + 1 >= m_len)) m_col = 0;
            else m_col = m_col + 1;
            if (ipc) begin
                if (rise) begin
                    if (m_hcnt != 0) m_len = m_hcnt;
                    m_hcnt = 1;
                end else if (m_hcnt < 1023) begin
                    m_hcnt = m_hcnt + 1;
                end
                m_prev_hs = hs;
            end
            m_bank = nb;
            m_v1   = vs;
        end
        exp_q.push_back(o);
    endtask

    // Monitor: one output sample per clock against the head of the scoreboard, plus hsync_o spacing.
    int cyc = 0;
    int last_rise = -1;
    bit hs_prev_o = 0;
    always @(negedge clk12m) begin
        exp_t e;
        cyc = cyc + 1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks = checks + 1;
            if (hsync_o !== e.hs || vsync_o !== e.vs ||
                (e.known && (blank_o !== e.bl || rgb_o !== e.rgb))) begin
                errors = errors + 1;
                $display("FAIL pixel cyc=%0d got hs=%b vs=%b bl=%b rgb=%02h want hs=%b vs=%b bl=%b rgb=%02h known=%b",
                         cyc, hsync_o, vsync_o, blank_o, rgb_o, e.hs, e.vs, e.bl, e.rgb, e.known);
            end
        end
        if (exp_period == 0) begin
            last_rise = -1;
        end else if (hsync_o === 1'b1 && !hs_prev_o) begin
            if (last_rise >= 0) begin
                checks = checks + 1;
                if (cyc - last_rise != exp_period) begin
                    errors = errors + 1;
                    $display("FAIL hsync_period cyc=%0d got %0d want %0d", cyc, cyc - last_rise, exp_period);
                end
            end
            last_rise = cyc;
        end
        hs_prev_o = (hsync_o === 1'b1);
    end

    // Stimulus
    bit ph = 0;
    int vs_left = 0;

    task automatic tick(input bit rst);
        reset   = rst;
        clk6m   = ph;
        vsync_i = (vs_left > 0);
        if (vs_left > 0) vs_left = vs_left - 1;
        model_edge(rst, ph, hsync_i, vsync_i, blank_i, rgb_i);
        @(posedge clk12m);
        #1;
        ph = ~ph;
    endtask

    // mode 0: rgb = index, 1: index with blank on pixels 0..15, 2: random, 3: all zero
    task automatic send_line(input int len, input int mode, input int rst_at, input int vs_at);
        for (int p = 0; p < len; p++) begin
            hsync_i = (p < 20);
            case (mode)
                0: begin blank_i = 0; rgb_i = 8'(p); end
                1: begin blank_i = (p < 16); rgb_i = 8'(p); end
                2: begin blank_i = ($urandom_range(0, 7) == 0); rgb_i = 8'($urandom); end
                default: begin blank_i = 0; rgb_i = 8'h00; end
            endcase
            if (p == vs_at) vs_left = 3;
            tick(p == rst_at);
            tick(0);
        end
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 1024; i++)
                m_mem[b][i] = -1;
        hsync_i = 0; blank_i = 0; rgb_i = 8'h00; vsync_i = 0; clk6m = 0; reset = 1;

        // Reset, then fill both banks with zeros so later blank/rgb checks are fully defined.
        repeat (4) tick(1);
        repeat (3) send_line(512, 3, -1, -1);
        hsync_i = 0; blank_i = 0; rgb_i = 8'h00;
        repeat (3) tick(1);

        // Constant inputs: dark output with hsync_o every DEFAULT_LEN cycles.
        exp_period = DEFLEN;
        repeat (1300) tick(0);
        exp_period = 0;

        // 400-pixel lines: ramp, leading blank, random content, one 3-cycle vsync pulse.
        repeat (2) send_line(400, 0, -1, -1);
        exp_period = 400;
        send_line(400, 0, -1, -1);
        send_line(400, 1, -1, -1);
        send_line(400, 1, -1, 123);
        send_line(400, 2, -1, -1);
        send_line(400, 2, -1, 301);
        send_line(400, 0, -1, -1);
        exp_period = 0;

        // 600-pixel lines: tail beyond the buffer reads as blank, replay period becomes 600.
        repeat (2) send_line(600, 0, -1, -1);
        exp_period = 600;
        send_line(600, 2, -1, -1);
        send_line(600, 0, -1, -1);
        exp_period = 0;

        // Reset in the middle of a line, then resume normal lines.
        send_line(400, 2, -1, -1);
        send_line(400, 2, $urandom_range(50, 350), -1);
        repeat (2) send_line(400, 1, -1, -1);
        send_line(400, 2, -1, 77);

        hsync_i = 0;
        repeat (10) tick(0);
        @(negedge clk12m);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_convert_lx45.md
SCAN_CONVERT_LX45 -- requirements
Module: scan_convert_lx45

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 512, giving the pixels stored per line buffer.
REQ-002 SHALL have parameter HSYNC_W, default 32, giving the width of hsync_o pulses in clk12m cycles.
REQ-003 SHALL have parameter DEFAULT_LEN, default 384, giving the line length in pixels used before the first line is measured.
REQ-004 SHALL have the following ports:
- clk12m  in  1  sole clock; all logic is clocked on its rising edge.
- reset  in  1  synchronous, active-high reset.
- clk6m  in  1  pixel strobe, synchronous to clk12m; high on alternate cycles; sampled as data, never used as a clock.
- hsync_i  in  1  15 kHz input horizontal sync, active-high.
- vsync_i  in  1  input vertical sync, active-high.
- blank_i  in  1  input blank, active-high.
- rgb_i  in  8  input pixel, {B[1:0], G[2:0], R[2:0]}.
- hsync_o  out  1  doubled-rate horizontal sync, active-high.
- vsync_o  out  1  output vertical sync, active-high.
- blank_o  out  1  output blank, active-high.
- rgb_o  out  8  output pixel, same format as rgb_i.

Function
REQ-005 SHALL treat a clk12m cycle with clk6m==1 as an input pixel cycle (ipc); all input-side logic advances only on ipc.
REQ-006 SHALL detect a rising edge of hsync_i by comparing it with its value captured on the previous ipc.
REQ-007 SHALL keep a 10-bit input counter hcount_i:
- increments on each ipc and saturates at 1023;
- on an ipc carrying an hsync_i rising edge, is set to 1 after the pixel on that ipc is written at address 0.
REQ-008 SHALL write {blank_i, rgb_i} on each ipc to write-bank wsel at address hcount_i, and only when hcount_i < BUF_DEPTH.
REQ-009 SHALL, on an hsync_i rising edge:
- toggle wsel;
- latch line_len = hcount_i, except when hcount_i is 0, in which case line_len keeps its value.
REQ-010 SHALL keep a 10-bit output counter hcount_o that advances every clk12m cycle:
- wraps to 0 after line_len-1, so every input line yields exactly two output lines;
- is forced to 0 on an hsync_i rising edge, keeping the output phase-locked.
REQ-011 SHALL read bank ~wsel at address hcount_o through a synchronous (1-cycle) read.
REQ-012 SHALL treat any read address at or above BUF_DEPTH as {1, 8'h00}.
REQ-013 SHALL drive blank_o from the stored blank bit, and SHALL drive rgb_o to the stored rgb, or 0 when blank_o is 1.
REQ-014 SHALL assert hsync_o while hcount_o < HSYNC_W, delayed by one cycle to stay aligned with the RAM read.
REQ-015 SHALL drive vsync_o as vsync_i delayed by 2 clk12m cycles.
REQ-016 SHALL register all outputs; pixel, blank and hsync_o latency from hcount_o is exactly 2 cycles.
REQ-017 SHALL give the write priority to the bank being written when a read and a write target the same bank; this cannot occur except while wsel is toggling.

Reset
REQ-018 SHALL, on reset, clear hcount_i, hcount_o, wsel, the edge-detect register and all output registers, and set line_len to DEFAULT_LEN.
REQ-019 SHALL, on reset asserted mid-line, abandon the line; buffer contents are not cleared and the outputs are 0 on the following cycle.

Structure
REQ-020 SHALL place BUF_DEPTH, the counter width (10) and the pixel-word width (9 = blank + rgb) in a shared package, scan_convert_pkg.
REQ-021 SHALL implement storage as one sub-module, line_buf_dp: simple dual-port RAM of 2*BUF_DEPTH x 9, with the bank bit as the address MSB.

Verification
REQ-022 SHALL cover: reset, then constant inputs -> all outputs 0, and hsync_o pulses every 384 clk12m cycles.
REQ-023 SHALL cover: input lines of 400 pixels with rgb_i = pixel index mod 256 -> each line replayed twice, 400 clk12m cycles per output line, rgb_o = 0..255,0..143.
REQ-024 SHALL cover: blank_i = 1 for pixels 0..15 -> blank_o = 1 and rgb_o = 0 for the first 16 pixels of both replays.
REQ-025 SHALL cover: a line of 600 pixels -> pixels 512..599 read back as blanked, and line_len = 600.
REQ-026 SHALL cover: a vsync_i pulse of 3 cycles -> vsync_o is an identical pulse delayed by exactly 2 cycles.
REQ-027 SHALL cover: reset asserted mid-line -> all outputs 0 on the following cycle, and hcount_o restarts at 0.
